phys_reg_freelist: RTL and testbench

PHYS_REG_FREELIST -- requirements
Module: phys_reg_freelist

---
 rtl/phys_reg_freelist_if.sv | 40 ++++
 rtl/phys_reg_freelist.sv | 119 +++++++++++
 tb/tb_phys_reg_freelist.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_freelist_if.sv
// ---------------------------------------------------------------------------
// phys_reg_freelist_if
//
// Purpose: bundles the rename-side allocate port, the commit-side free port
// and the status outputs of the physical register free list.
//
// Signals:
//   alloc_req   rename asks for one new destination tag this cycle
//   alloc_valid alloc_tag is usable this cycle
//   alloc_tag   tag handed to rename when alloc_req && alloc_valid
//   free_valid  commit returns one old tag this cycle
//   free_tag    tag being returned
//   stall       alloc_req && !alloc_valid, feeds rename stall_in
//   free_count  number of tags currently held
//   overflow    sticky error flag (free dropped while list was full)
//
// Modports: master = rename/commit side, slave = free list.
// ---------------------------------------------------------------------------
interface phys_reg_freelist_if #(
  parameter int TAG_W = 6
);
  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             free_valid;
  logic [TAG_W-1:0] free_tag;
  logic             stall;
  logic [TAG_W-1:0] free_count;
  logic             overflow;

  modport master (
    output alloc_req, free_valid, free_tag,
    input  alloc_valid, alloc_tag, stall, free_count, overflow
  );

  modport slave (
    input  alloc_req, free_valid, free_tag,
    output alloc_valid, alloc_tag, stall, free_count, overflow
  );
endinterface

// File: rtl/phys_reg_freelist.sv
// ---------------------------------------------------------------------------
// phys_reg_freelist
//
// Purpose: circular FIFO of free physical register tags for register rename.
// Holds DEPTH = NUM_PREGS - NUM_AREGS entries with head/tail pointers and an
// explicit occupancy count. Allocation is zero-latency: alloc_tag is the head
// entry driven combinationally, and the pop happens on the rising edge.
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset; refills the list with tags
//        NUM_AREGS..NUM_PREGS-1 and clears overflow
//   fl   phys_reg_freelist_if.slave (alloc/free handshake and status)
//
// Optional feature: define FREELIST_BYPASS_EN to let a tag being freed while
// the list is empty be handed straight to rename in the same cycle.
// ---------------------------------------------------------------------------
module phys_reg_freelist #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = 6
) (
  input logic                clk,
  input logic                rst,
  phys_reg_freelist_if.slave fl
);

  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] DEPTH_CNT = TAG_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic freeOk;
  logic empty;
  logic full;
  logic bypass;
  logic bypassTake;
  logic pop;
  logic push;
  logic allocValid;

  // Tag 0 is x0, which is never renamed, so a free of tag 0 is a no-op.
  always_comb begin
    freeOk = fl.free_valid && (fl.free_tag != '0);
    empty  = (count_q == '0);
    full   = (count_q == DEPTH_CNT);
  end

`ifdef FREELIST_BYPASS_EN
  // An empty list can still serve rename from the tag commit is returning.
  assign bypass = empty && freeOk;
`else
  assign bypass = 1'b0;
`endif

  assign allocValid     = !empty || bypass;
  assign fl.alloc_valid = allocValid;
  assign fl.alloc_tag   = bypass ? fl.free_tag : mem_q[head_q];
  assign fl.stall       = fl.alloc_req && !allocValid;
  assign fl.free_count  = count_q;
  assign fl.overflow    = overflow_q;

  // A pop in the same cycle frees a slot, so a free at full only overflows
  // when nothing is being allocated. A bypassed tag never touches the FIFO.
  always_comb begin
    pop        = fl.alloc_req && !empty;
    bypassTake = fl.alloc_req && bypass;
    push       = freeOk && !bypassTake && (!full || pop);

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + TAG_W'(1);
      2'b01:   count_d = count_q - TAG_W'(1);
      default: count_d = count_q;
    endcase

    if (freeOk && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_W'(NUM_AREGS + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= DEPTH_CNT;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= fl.free_tag;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_freelist.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_freelist
//
// Self-checking bench for phys_reg_freelist. Every cycle's outputs are
// compared against a queue-based reference model; a directed vector table
// and hand-written sequences cover the named corner cases, followed by
// randomized traffic. Honors FREELIST_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_phys_reg_freelist;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int TAG_W     = 6;
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
`ifdef FREELIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  phys_reg_freelist_if #(.TAG_W(TAG_W)) flIf ();

  phys_reg_freelist #(
    .NUM_PREGS(NUM_PREGS),
    .NUM_AREGS(NUM_AREGS),
    .TAG_W    (TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fl (flIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model: queue of free tags in allocation order, plus sticky flag.
  int q[$];
  bit ovfM;
  bit modelKnown;

  // Outputs sampled before the edge in the most recent applyStimulus call.
  bit aValid;
  int aTag;
  bit aStall;
  int aCount;
  bit aOvf;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareModel(input bit req, input bit fv, input int ft);
    bit freeOk;
    bit byp;
    bit expValid;
    int expTag;
    freeOk   = fv && (ft != 0);
    byp      = BYP && (q.size() == 0) && freeOk;
    expValid = (q.size() != 0) || byp;
    expTag   = (q.size() != 0) ? q[0] : ft;
    checkOutput("model alloc_valid", int'(aValid), int'(expValid));
    checkOutput("model stall", int'(aStall), int'(req && !expValid));
    checkOutput("model free_count", aCount, q.size());
    checkOutput("model overflow", int'(aOvf), int'(ovfM));
    if (expValid) checkOutput("model alloc_tag", aTag, expTag);
  endtask

  task automatic updateModel(input bit req, input bit fv, input int ft, input bit r);
    bit freeOk;
    bit wasFull;
    bit take;
    if (r) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(NUM_AREGS + i);
      ovfM       = 1'b0;
      modelKnown = 1'b1;
    end else if (modelKnown) begin
      freeOk = fv && (ft != 0);
      if (BYP && q.size() == 0 && freeOk && req) begin
        // tag goes straight to rename, list untouched
      end else begin
        wasFull = (q.size() == DEPTH);
        take    = req && (q.size() != 0);
        if (take) void'(q.pop_front());
        if (freeOk) begin
          if (wasFull && !take) ovfM = 1'b1;
          else q.push_back(ft);
        end
      end
    end
  endtask

  // Drives one cycle: inputs set just after an edge, outputs sampled 2ns
  // later, then the rising edge is taken and the model advanced.
  task automatic applyStimulus(input bit req, input bit fv, input int ft, input bit r);
    flIf.alloc_req  = req;
    flIf.free_valid = fv;
    flIf.free_tag   = TAG_W'(ft);
    rst             = r;
    #2;
    aValid = flIf.alloc_valid;
    aTag   = int'(flIf.alloc_tag);
    aStall = flIf.stall;
    aCount = int'(flIf.free_count);
    aOvf   = flIf.overflow;
    if (modelKnown && !r) compareModel(req, fv, ft);
    @(posedge clk);
    #1;
    updateModel(req, fv, ft, r);
  endtask

  typedef struct {
    bit req;
    bit fv;
    int ft;
    bit expValid;
    int expTag;
    bit expStall;
    int expCount;
    bit expOvf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    errors     = 0;
    checks     = 0;
    modelKnown = 1'b0;
    ovfM       = 1'b0;
    rst             = 1'b1;
    flIf.alloc_req  = 1'b0;
    flIf.free_valid = 1'b0;
    flIf.free_tag   = '0;
    @(posedge clk);
    #1;

    // Directed vectors after reset: three allocations, a free of x0, a real free.
    vecs[0] = '{1'b1, 1'b0, 0, 1'b1, 32, 1'b0, 32, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 0, 1'b1, 33, 1'b0, 31, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 0, 1'b1, 34, 1'b0, 30, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 0, 1'b1, 35, 1'b0, 29, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 0, 1'b1, 35, 1'b0, 29, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 9, 1'b1, 35, 1'b0, 29, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 0, 1'b1, 35, 1'b0, 30, 1'b0};

    $display("[TB] reset and directed vectors");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].req, vecs[i].fv, vecs[i].ft, 1'b0);
      checkOutput($sformatf("vec%0d alloc_valid", i), int'(aValid), int'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d alloc_tag", i), aTag, vecs[i].expTag);
      checkOutput($sformatf("vec%0d stall", i), int'(aStall), int'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d free_count", i), aCount, vecs[i].expCount);
      checkOutput($sformatf("vec%0d overflow", i), int'(aOvf), int'(vecs[i].expOvf));
    end

    // Drain all 32 tags, then an allocation must stall.
    $display("[TB] drain to empty");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput($sformatf("drain%0d tag", i), aTag, NUM_AREGS + i);
    end
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("empty alloc_valid", int'(aValid), 0);
    checkOutput("empty stall", int'(aStall), 1);
    checkOutput("empty free_count", aCount, 0);

    // Free tag 5 while empty with a pending allocation.
    applyStimulus(1'b1, 1'b1, 5, 1'b0);
    if (BYP) begin
      checkOutput("bypass alloc_valid", int'(aValid), 1);
      checkOutput("bypass alloc_tag", aTag, 5);
      checkOutput("bypass stall", int'(aStall), 0);
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      checkOutput("bypass free_count after", aCount, 0);
    end else begin
      checkOutput("nobypass stall", int'(aStall), 1);
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      checkOutput("nobypass next alloc_valid", int'(aValid), 1);
      checkOutput("nobypass next alloc_tag", aTag, 5);
      checkOutput("nobypass next free_count", aCount, 1);
    end

    // Pointer wrap: after a full drain both pointers are back at slot 0.
    $display("[TB] pointer wrap");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 12, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("wrap alloc_tag", aTag, 12);
    checkOutput("wrap free_count", aCount, 1);

    // Overflow on free while full; none when an allocation frees the slot.
    $display("[TB] overflow cases");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 7, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("ovf flag", int'(aOvf), 1);
    checkOutput("ovf free_count", aCount, 32);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 7, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("full swap overflow", int'(aOvf), 0);
    checkOutput("full swap free_count", aCount, 32);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("full swap tail tag", aTag, 7);

    // Reset mid-stream at count 10 with overflow set, in-flight traffic discarded.
    $display("[TB] mid-stream reset");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 7, 1'b0);
    for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3, 1'b1);
    checkOutput("pre-reset free_count", aCount, 10);
    checkOutput("pre-reset overflow", int'(aOvf), 1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("post-reset free_count", aCount, 32);
    checkOutput("post-reset alloc_tag", aTag, 32);
    checkOutput("post-reset overflow", int'(aOvf), 0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      bit req;
      bit fv;
      int ft;
      bit r;
      req = ($urandom_range(0, 99) < 55);
      fv  = ($urandom_range(0, 99) < 50);
      ft  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, NUM_PREGS - 1));
      r   = ($urandom_range(0, 199) == 0);
      applyStimulus(req, fv, ft, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
